mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/grant and RAM bus bundle for mem_arbiter.
// The slave side is the arbiter; the master side is the requesters plus the RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 14
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic [31:0]       d_addr;
  logic [3:0]        d_we;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic [3:0]        dbg_we;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_d;
  logic [31:0]       ram_q;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_addr, d_we, d_wdata,
    input  dbg_req, dbg_addr, dbg_we, dbg_wdata,
    input  ram_q,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_en, ram_addr, ram_we, ram_d
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_addr, d_we, d_wdata,
    output dbg_req, dbg_addr, dbg_we, dbg_wdata,
    output ram_q,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_en, ram_addr, ram_we, ram_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port single-port-RAM arbiter (fetch, data, debug) with read tag pipeline.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority d > if > dbg.
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LAT    = 1
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_IF  = 2'd0,
    OWN_D   = 2'd1,
    OWN_DBG = 2'd2
  } own_e;

  logic [2:0] req;
  logic [2:0] gnt;
  own_e       own;
  logic       rd;

  // Grants are gated by reset so all outputs read 0 while rst_n is low.
  assign req = {bus.dbg_req, bus.d_req, bus.if_req} & {3{rst_n}};

`ifdef MEM_ARB_RR_EN
  own_e last_q;
  own_e last_d;

  always_comb begin
    gnt = 3'b000;
    case (last_q)
      OWN_IF: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      OWN_D: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (|gnt) last_d = own;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_DBG;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    gnt = 3'b000;
    if (req[1])      gnt = 3'b010;
    else if (req[0]) gnt = 3'b001;
    else if (req[2]) gnt = 3'b100;
  end
`endif

  always_comb begin
    bus.ram_en   = |gnt;
    bus.ram_addr = '0;
    bus.ram_we   = 4'b0000;
    bus.ram_d    = 32'h0;
    rd           = 1'b0;
    own          = OWN_IF;
    unique case (1'b1)
      gnt[0]: begin
        bus.ram_addr = bus.if_addr[ADDR_W+1:2];
        rd           = 1'b1;
        own          = OWN_IF;
      end
      gnt[1]: begin
        bus.ram_addr = bus.d_addr[ADDR_W+1:2];
        bus.ram_we   = bus.d_we;
        bus.ram_d    = bus.d_wdata;
        rd           = (bus.d_we == 4'b0000);
        own          = OWN_D;
      end
      gnt[2]: begin
        bus.ram_addr = bus.dbg_addr[ADDR_W+1:2];
        bus.ram_we   = bus.dbg_we;
        bus.ram_d    = bus.dbg_wdata;
        rd           = (bus.dbg_we == 4'b0000);
        own          = OWN_DBG;
      end
      default: ;
    endcase
  end

  assign bus.if_gnt  = gnt[0];
  assign bus.d_gnt   = gnt[1];
  assign bus.dbg_gnt = gnt[2];

  logic [LAT-1:0] vld_q;
  own_e           own_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) own_q[i] <= OWN_IF;
    end else begin
      vld_q[0] <= rd;
      own_q[0] <= own;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign bus.if_rvalid  = vld_q[LAT-1] && (own_q[LAT-1] == OWN_IF);
  assign bus.d_rvalid   = vld_q[LAT-1] && (own_q[LAT-1] == OWN_D);
  assign bus.dbg_rvalid = vld_q[LAT-1] && (own_q[LAT-1] == OWN_DBG);

  assign bus.if_rdata  = bus.ram_q;
  assign bus.d_rdata   = bus.ram_q;
  assign bus.dbg_rdata = bus.ram_q;

  // Upper address bits alias and byte offsets belong to the requester.
  logic unused_addr;
  assign unused_addr = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                         bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0],
                         bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(gnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one LAT=1 and one LAT=2 instance share stimulus.
// A reference arbiter and memory model predict grants, RAM strobes and routed read data.
module tb_mem_arbiter;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req = 0, d_req = 0, dbg_req = 0;
  logic [31:0] if_addr = 0, d_addr = 0, dbg_addr = 0;
  logic [3:0]  d_we = 0, dbg_we = 0;
  logic [31:0] d_wdata = 0, dbg_wdata = 0;

  mem_arbiter_if #(.ADDR_W(AW)) bus1 ();
  mem_arbiter_if #(.ADDR_W(AW)) bus2 ();

  mem_arbiter #(.ADDR_W(AW), .LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_arbiter #(.ADDR_W(AW), .LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus1.if_req = if_req;     assign bus2.if_req = if_req;
  assign bus1.if_addr = if_addr;   assign bus2.if_addr = if_addr;
  assign bus1.d_req = d_req;       assign bus2.d_req = d_req;
  assign bus1.d_addr = d_addr;     assign bus2.d_addr = d_addr;
  assign bus1.d_we = d_we;         assign bus2.d_we = d_we;
  assign bus1.d_wdata = d_wdata;   assign bus2.d_wdata = d_wdata;
  assign bus1.dbg_req = dbg_req;   assign bus2.dbg_req = dbg_req;
  assign bus1.dbg_addr = dbg_addr; assign bus2.dbg_addr = dbg_addr;
  assign bus1.dbg_we = dbg_we;     assign bus2.dbg_we = dbg_we;
  assign bus1.dbg_wdata = dbg_wdata;
  assign bus2.dbg_wdata = dbg_wdata;

  function automatic logic [31:0] init_word(int a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0003);
  endfunction

  // RAM devices
  logic [31:0] mem1 [int];
  logic [31:0] mem2 [int];
  logic [31:0] p1 = 0, p2a = 0, p2b = 0;
  assign bus1.ram_q = p1;
  assign bus2.ram_q = p2b;

  always @(posedge clk) begin : ram1
    int a;
    logic [31:0] w;
    if (bus1.ram_en) begin
      a = int'(bus1.ram_addr);
      w = mem1.exists(a) ? mem1[a] : init_word(a);
      if (bus1.ram_we == 4'b0) p1 <= w;
      else begin
        for (int b = 0; b < 4; b++)
          if (bus1.ram_we[b]) w[8*b +: 8] = bus1.ram_d[8*b +: 8];
        mem1[a] = w;
      end
    end
  end

  always @(posedge clk) begin : ram2
    int a;
    logic [31:0] w;
    p2b <= p2a;
    if (bus2.ram_en) begin
      a = int'(bus2.ram_addr);
      w = mem2.exists(a) ? mem2[a] : init_word(a);
      if (bus2.ram_we == 4'b0) p2a <= w;
      else begin
        for (int b = 0; b < 4; b++)
          if (bus2.ram_we[b]) w[8*b +: 8] = bus2.ram_d[8*b +: 8];
        mem2[a] = w;
      end
    end
  end

  // DUT observation arrays, index 0 = LAT1, 1 = LAT2
  logic [2:0]    gv [2];
  logic [2:0]    rv [2];
  logic          ren [2];
  logic [AW-1:0] radr [2];
  logic [3:0]    rwe [2];
  logic [31:0]   rdv [2];
  logic [31:0]   rdat [2][3];
  assign gv[0] = {bus1.dbg_gnt, bus1.d_gnt, bus1.if_gnt};
  assign gv[1] = {bus2.dbg_gnt, bus2.d_gnt, bus2.if_gnt};
  assign rv[0] = {bus1.dbg_rvalid, bus1.d_rvalid, bus1.if_rvalid};
  assign rv[1] = {bus2.dbg_rvalid, bus2.d_rvalid, bus2.if_rvalid};
  assign ren[0] = bus1.ram_en;    assign ren[1] = bus2.ram_en;
  assign radr[0] = bus1.ram_addr; assign radr[1] = bus2.ram_addr;
  assign rwe[0] = bus1.ram_we;    assign rwe[1] = bus2.ram_we;
  assign rdv[0] = bus1.ram_d;     assign rdv[1] = bus2.ram_d;
  assign rdat[0][0] = bus1.if_rdata;
  assign rdat[0][1] = bus1.d_rdata;
  assign rdat[0][2] = bus1.dbg_rdata;
  assign rdat[1][0] = bus2.if_rdata;
  assign rdat[1][1] = bus2.d_rdata;
  assign rdat[1][2] = bus2.dbg_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          own;
    logic [31:0] data;
  } exp_t;
  exp_t        sbq [2][$];
  logic [31:0] mmem [int];
  int          last_own = 2;
  logic [2:0]  exp_g = 0;

  function automatic logic [31:0] model_rd(int a);
    return mmem.exists(a) ? mmem[a] : init_word(a);
  endfunction

  function automatic logic [2:0] pick(logic [2:0] r, int last);
`ifdef MEM_ARB_RR_EN
    for (int i = 1; i <= 3; i++) begin
      int p;
      p = (last + i) % 3;
      if (r[p]) return 3'b001 << p;
    end
    return 3'b000;
`else
    if (last < 0) return 3'b000;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    if (r[2]) return 3'b100;
    return 3'b000;
`endif
  endfunction

  // Scoreboard monitor: predicts and checks every sampled cycle
  always @(negedge clk) begin : mon
    logic [2:0]  eg, erv;
    logic [31:0] ed, a, wd, w;
    logic [3:0]  we;
    int          p, wa;
    exp_t        e;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({gv[k], rv[k], ren[k], rwe[k], radr[k], rdv[k]} !== '0) begin
          bad++;
          $display("FAIL reset_outputs dut%0d got=%h exp=0", k,
                   {gv[k], rv[k], ren[k], rwe[k], radr[k], rdv[k]});
        end
        sbq[k].delete();
      end
      last_own = 2;
      exp_g = 3'b000;
    end else begin
      for (int k = 0; k < 2; k++) begin
        erv = 3'b000;
        ed = 32'h0;
        p = 0;
        if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
          e = sbq[k].pop_front();
          erv = 3'b001 << e.own;
          ed = e.data;
          p = e.own;
        end
        total++;
        if (rv[k] !== erv) begin
          bad++;
          $display("FAIL sb_rvalid dut%0d cyc=%0d got=%b exp=%b", k, cyc, rv[k], erv);
        end
        if (erv != 3'b000) begin
          total++;
          if (rdat[k][p] !== ed) begin
            bad++;
            $display("FAIL sb_rdata dut%0d port=%0d got=%h exp=%h", k, p, rdat[k][p], ed);
          end
        end
      end
      eg = pick({dbg_req, d_req, if_req}, last_own);
      exp_g = eg;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (gv[k] !== eg) begin
          bad++;
          $display("FAIL sb_gnt dut%0d cyc=%0d got=%b exp=%b", k, cyc, gv[k], eg);
        end
      end
      if (eg == 3'b000) begin
        for (int k = 0; k < 2; k++) begin
          total++;
          if (ren[k] !== 1'b0 || rwe[k] !== 4'b0) begin
            bad++;
            $display("FAIL sb_idle dut%0d got=%b/%b exp=0/0", k, ren[k], rwe[k]);
          end
        end
      end else begin
        p = eg[0] ? 0 : (eg[1] ? 1 : 2);
        a = (p == 0) ? if_addr : ((p == 1) ? d_addr : dbg_addr);
        we = (p == 0) ? 4'b0 : ((p == 1) ? d_we : dbg_we);
        wd = (p == 1) ? d_wdata : dbg_wdata;
        wa = int'((a >> 2) & 32'h3FFF);
        for (int k = 0; k < 2; k++) begin
          total++;
          if (ren[k] !== 1'b1 || radr[k] !== wa[AW-1:0] || rwe[k] !== we) begin
            bad++;
            $display("FAIL sb_ram dut%0d got=%b/%h/%b exp=1/%h/%b",
                     k, ren[k], radr[k], rwe[k], wa[AW-1:0], we);
          end
          if (p != 0) begin
            total++;
            if (rdv[k] !== wd) begin
              bad++;
              $display("FAIL sb_ram_d dut%0d got=%h exp=%h", k, rdv[k], wd);
            end
          end
        end
        if (we == 4'b0) begin
          e.own = p;
          e.data = model_rd(wa);
          e.due = cyc + 1;
          sbq[0].push_back(e);
          e.due = cyc + 2;
          sbq[1].push_back(e);
        end else begin
          w = model_rd(wa);
          for (int b = 0; b < 4; b++)
            if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
          mmem[wa] = w;
        end
`ifdef MEM_ARB_RR_EN
        last_own = p;
`endif
      end
    end
  end

  task automatic idle(int n);
    @(posedge clk); #1;
    if_req = 0; d_req = 0; dbg_req = 0; d_we = 0; dbg_we = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    if_req = 1; d_req = 1; dbg_req = 1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (gv[0] !== 3'b0 || rv[1] !== 3'b0 || bus1.ram_en !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold got=%b/%b/%b exp=0/0/0", gv[0], rv[1], bus1.ram_en);
      end
    end
    @(posedge clk); #1;
    if_req = 0; d_req = 0; dbg_req = 0;
    rst_n = 1;
  endtask

  task automatic test_contention;
    logic [2:0] tab [6];
`ifdef MEM_ARB_RR_EN
    tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    tab = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h10;
    d_req = 1; d_addr = 32'h20; d_we = 0;
    dbg_req = 1; dbg_addr = 32'h30; dbg_we = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (gv[k] !== tab[i]) begin
          bad++;
          $display("FAIL contention dut%0d step=%0d got=%b exp=%b", k, i, gv[k], tab[i]);
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_fetch_read;
    logic [31:0] ex;
    ex = model_rd(32'h40);
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    total++;
    if (bus1.if_gnt !== 1'b1 || bus1.ram_addr !== 14'h40 ||
        bus1.ram_en !== 1'b1 || bus1.ram_we !== 4'b0) begin
      bad++;
      $display("FAIL fetch_issue got=%b/%h/%b/%b exp=1/0040/1/0",
               bus1.if_gnt, bus1.ram_addr, bus1.ram_en, bus1.ram_we);
    end
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    total++;
    if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== ex) begin
      bad++;
      $display("FAIL fetch_resp got=%b/%h exp=1/%h", bus1.if_rvalid, bus1.if_rdata, ex);
    end
    idle(3);
  endtask

  task automatic test_write_alias;
    logic [31:0] ex;
    d_req = 1; d_addr = 32'h8; d_we = 4'b0100; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    total++;
    if (bus1.d_gnt !== 1'b1 || bus1.ram_addr !== 14'h2 ||
        bus1.ram_we !== 4'b0100 || bus1.ram_d !== 32'hAABBCCDD) begin
      bad++;
      $display("FAIL write_issue got=%b/%h/%b/%h exp=1/0002/0100/aabbccdd",
               bus1.d_gnt, bus1.ram_addr, bus1.ram_we, bus1.ram_d);
    end
    @(posedge clk); #1;
    d_req = 0; d_we = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (rv[0] !== 3'b0 || rv[1] !== 3'b0) begin
        bad++;
        $display("FAIL write_no_rvalid got=%b/%b exp=000/000", rv[0], rv[1]);
      end
    end
    ex = init_word(2);
    ex[23:16] = 8'hBB;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'hFFFF_0008;
    @(negedge clk);
    total++;
    if (bus1.ram_addr !== 14'h2) begin
      bad++;
      $display("FAIL alias_addr got=%h exp=0002", bus1.ram_addr);
    end
    @(posedge clk); #1;
    if_req = 0;
    @(negedge clk);
    total++;
    if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== ex) begin
      bad++;
      $display("FAIL alias_read got=%b/%h exp=1/%h", bus1.if_rvalid, bus1.if_rdata, ex);
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    logic [2:0] e1 [6];
    logic [2:0] e2 [6];
    e1 = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
    e2 = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b000};
    dbg_addr = 32'h44; if_addr = 32'h48; d_addr = 32'h4C;
    dbg_we = 0; d_we = 0;
    for (int i = 0; i < 6; i++) begin
      dbg_req = (i == 0);
      if_req = (i == 1);
      d_req = (i == 2);
      @(negedge clk);
      total++;
      if (rv[0] !== e1[i] || rv[1] !== e2[i]) begin
        bad++;
        $display("FAIL b2b_order step=%0d got=%b/%b exp=%b/%b", i, rv[0], rv[1], e1[i], e2[i]);
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  task automatic test_reset_midflight;
    d_req = 1; d_addr = 32'h60; d_we = 0;
    @(negedge clk);
    total++;
    if (bus2.d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_grant got=%b exp=1", bus2.d_gnt);
    end
    @(posedge clk); #1;
    d_req = 0; rst_n = 0; if_req = 1; if_addr = 32'h64;
    @(negedge clk);
    total++;
    if (gv[1] !== 3'b0 || rv[1] !== 3'b0 || bus2.ram_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_out got=%b/%b/%b exp=0/0/0", gv[1], rv[1], bus2.ram_en);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus2.d_rvalid !== 1'b0 || bus2.if_rvalid !== (i == 2)) begin
        bad++;
        $display("FAIL mid_after step=%0d got=%b/%b exp=0/%b",
                 i, bus2.d_rvalid, bus2.if_rvalid, (i == 2));
      end
      @(posedge clk); #1;
      if_req = 0;
    end
    idle(2);
  endtask

  task automatic test_random;
    logic [2:0] r;
    int         wt [3];
    wt = '{0, 0, 0};
    for (int n = 0; n < 300; n++) begin
      r = {dbg_req, d_req, if_req};
      if (!r[0] || exp_g[0]) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFF0_00FC;
      end
      if (!r[1] || exp_g[1]) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = $urandom & 32'hFFF0_00FF;
        d_we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        d_wdata = $urandom;
      end
      if (!r[2] || exp_g[2]) begin
        dbg_req = ($urandom_range(0, 3) == 0);
        dbg_addr = $urandom & 32'h000F_00FC;
        dbg_we = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        dbg_wdata = $urandom;
      end
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      r = {dbg_req, d_req, if_req};
      for (int p = 0; p < 3; p++) begin
        wt[p] = (r[p] && !gv[0][p]) ? wt[p] + 1 : 0;
        total++;
        if (wt[p] >= 3) begin
          bad++;
          $display("FAIL rr_fairness port=%0d got_wait=%0d exp_max=2", p, wt[p]);
        end
      end
`endif
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_fetch_read();
    test_write_alias();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    idle(4);
    total++;
    if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d exp=0/0", sbq[0].size(), sbq[1].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
